// File: rtl/ram_port_ctrl.sv
// ---------------------------------------------------------------------------
// ram_port_ctrl
//
// Bridges a valid/ready request stream onto a single-port, pipelined,
// byte-writable synchronous RAM and returns read data through an in-order
// valid/ready response stream. The RAM has a fixed read latency and no
// back-pressure, so every read is only accepted once a response-buffer slot
// is guaranteed for it. This keeps the buffer from ever overflowing.
//
// Parameters
//   ADDR_WIDTH  RAM word address width
//   BYTE_WIDTH  bits per byte lane
//   BYTE_NUM    byte lanes per word (MEM_WIDTH = BYTE_WIDTH*BYTE_NUM)
//   RD_LATENCY  cycles from RAM enable to valid read data (1..16)
//   RSP_DEPTH   response buffer entries (power of two, >= 2)
//
// Ports
//   clk_i, arstn_i              clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   request handshake
//   req_we_i                    byte write enables, all zero = read
//   req_addr_i, req_data_i      request word address and write data
//   rsp_valid_o / rsp_ready_i   read response handshake
//   rsp_data_o                  read response data (head of buffer)
//   ram_en_o, ram_rd_en_o       RAM port enable, output-register enable
//   ram_wr_en_o                 RAM byte write enables
//   ram_addr_o, ram_data_o      RAM address and write data
//   ram_data_i                  RAM read data
// ---------------------------------------------------------------------------
module ram_port_ctrl #(
  parameter int  ADDR_WIDTH = 10,
  parameter int  BYTE_WIDTH = 8,
  parameter int  BYTE_NUM   = 4,
  parameter int  RD_LATENCY = 1,
  parameter int  RSP_DEPTH  = 4,
  localparam int MEM_WIDTH  = BYTE_WIDTH * BYTE_NUM
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [BYTE_NUM-1:0]   req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [MEM_WIDTH-1:0]  req_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [MEM_WIDTH-1:0]  rsp_data_o,
  output logic                  ram_en_o,
  output logic                  ram_rd_en_o,
  output logic [BYTE_NUM-1:0]   ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [MEM_WIDTH-1:0]  ram_data_o,
  input  logic [MEM_WIDTH-1:0]  ram_data_i
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Parameter sanity, caught at elaboration.
  if (RD_LATENCY < 1 || RD_LATENCY > 16) begin : g_bad_latency
    $error("ram_port_ctrl: RD_LATENCY must lie within 1..16");
  end
  if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ram_port_ctrl: RSP_DEPTH must be a power of two, at least 2");
  end

  logic                  handshake;
  logic                  rd_handshake;
  logic                  rsp_push;
  logic                  rsp_pop;

  logic [RD_LATENCY-1:0] rd_pipe_q;
  logic [CNT_W-1:0]      outstanding_q;
  logic [CNT_W-1:0]      fill_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [MEM_WIDTH-1:0]  rsp_mem [RSP_DEPTH];

  // ---------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------

  // Outstanding counts reads in flight plus responses not yet popped, so a
  // read is only taken when its buffer slot is already reserved. Writes are
  // stalled by the same condition to keep ready independent of req_we_i.
  assign req_ready_o  = arstn_i && (outstanding_q < CNT_FULL);
  assign handshake    = req_valid_i && req_ready_o;
  assign rd_handshake = handshake && (req_we_i == '0);

  assign ram_en_o     = handshake;
  assign ram_rd_en_o  = 1'b1;
  assign ram_wr_en_o  = req_we_i & {BYTE_NUM{handshake}};
  assign ram_addr_o   = req_addr_i;
  assign ram_data_o   = req_data_i;

  // ---------------------------------------------------------------------
  // Read-in-flight tracker: bit k set means a read issued k+1 cycles ago.
  // When the top bit is set the RAM is presenting that read's data.
  // ---------------------------------------------------------------------
  if (RD_LATENCY == 1) begin : g_pipe_single
    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        rd_pipe_q <= '0;
      end else begin
        rd_pipe_q <= rd_handshake;
      end
    end
  end else begin : g_pipe_multi
    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        rd_pipe_q <= '0;
      end else begin
        rd_pipe_q <= {rd_pipe_q[RD_LATENCY-2:0], rd_handshake};
      end
    end
  end

  assign rsp_push = rd_pipe_q[RD_LATENCY-1];

  // ---------------------------------------------------------------------
  // Response buffer
  // ---------------------------------------------------------------------

  // A separate fill counter distinguishes empty from full, since the
  // pointers alone are equal in both cases.
  assign rsp_valid_o = (fill_q != '0);
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;

  // Head is read straight from storage; it is forced to zero when empty
  // so nothing stale is visible after reset.
  assign rsp_data_o  = rsp_valid_o ? rsp_mem[rd_ptr_q] : '0;

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk_i) begin
    if (rsp_push) begin
      rsp_mem[wr_ptr_q] <= ram_data_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (rsp_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (rsp_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({rsp_push, rsp_pop})
        2'b10:   fill_q <= fill_q + CNT_ONE;
        2'b01:   fill_q <= fill_q - CNT_ONE;
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Outstanding reads: reserved on read acceptance, released on pop.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      outstanding_q <= '0;
    end else begin
      case ({rd_handshake, rsp_pop})
        2'b10:   outstanding_q <= outstanding_q + CNT_ONE;
        2'b01:   outstanding_q <= outstanding_q - CNT_ONE;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_port_ctrl
//
// Two instances of ram_port_ctrl (RD_LATENCY=1/RSP_DEPTH=4 and
// RD_LATENCY=4/RSP_DEPTH=8) share request fields and rsp_ready, each with
// its own request valid, pipelined RAM model and reference model. The
// reference treats the design as a memory plus a FIFO of pending reads, each
// due RD_LATENCY+1 cycles after acceptance, bounded to RSP_DEPTH entries.
// ---------------------------------------------------------------------------
module tb_ram_port_ctrl;

  localparam int NI = 2;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 arstn;
  logic [NI-1:0]        req_valid;
  logic [NI-1:0]        req_ready;
  logic [3:0]           req_we;
  logic [9:0]           req_addr;
  logic [31:0]          req_data;
  logic [NI-1:0]        rsp_valid;
  logic                 rsp_ready;
  logic [NI-1:0][31:0]  rsp_data;
  logic [NI-1:0]        ram_en;
  logic [NI-1:0]        ram_rd_en;
  logic [NI-1:0][3:0]   ram_wr_en;
  logic [NI-1:0][9:0]   ram_addr;
  logic [NI-1:0][31:0]  ram_wdata;
  logic [NI-1:0][31:0]  ram_rdata;

  int cycle = 0;
  int compared = 0;
  int mismatched = 0;

  int          hs_count  [NI];
  int          hs_cyc    [NI];
  int          pop_count [NI];
  logic [31:0] pop_data  [NI][2048];
  int          pop_cyc   [NI][2048];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s (dut%0d): got %h, expected %h", name, inst, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one request to both instances until each has accepted it once.
  task automatic applyStimulus(input logic [3:0] we, input logic [9:0] addr,
                               input logic [31:0] data);
    logic [NI-1:0] done;
    done      = '0;
    req_we    = we;
    req_addr  = addr;
    req_data  = data;
    req_valid = '1;
    for (int t = 0; t < 50 && done != '1; t++) begin
      @(negedge clk);
      done = done | (req_valid & req_ready);
      @(posedge clk);
      #1;
      req_valid = req_valid & ~done;
    end
    checkOutput("request accepted", 0, 32'(done), 32'(2'b11));
    req_valid = '0;
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 4;
    localparam int DEP = (g == 0) ? 4 : 8;

    ram_port_ctrl #(
      .ADDR_WIDTH(10), .BYTE_WIDTH(8), .BYTE_NUM(4),
      .RD_LATENCY(LAT), .RSP_DEPTH(DEP)
    ) dut (
      .clk_i      (clk),
      .arstn_i    (arstn),
      .req_valid_i(req_valid[g]),
      .req_ready_o(req_ready[g]),
      .req_we_i   (req_we),
      .req_addr_i (req_addr),
      .req_data_i (req_data),
      .rsp_valid_o(rsp_valid[g]),
      .rsp_ready_i(rsp_ready),
      .rsp_data_o (rsp_data[g]),
      .ram_en_o   (ram_en[g]),
      .ram_rd_en_o(ram_rd_en[g]),
      .ram_wr_en_o(ram_wr_en[g]),
      .ram_addr_o (ram_addr[g]),
      .ram_data_o (ram_wdata[g]),
      .ram_data_i (ram_rdata[g])
    );

    // Pipelined byte-writable RAM; garbage on the pipe when not reading.
    logic [31:0] ram_mem  [1024];
    logic [31:0] ram_pipe [LAT];

    always @(posedge clk) begin
      for (int s = LAT - 1; s > 0; s--) ram_pipe[s] <= ram_pipe[s-1];
      ram_pipe[0] <= (ram_en[g] && ram_wr_en[g] == 4'h0) ? ram_mem[ram_addr[g]] : $urandom;
      if (ram_en[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_wr_en[g][b]) ram_mem[ram_addr[g]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
        end
      end
    end

    assign ram_rdata[g] = ram_pipe[LAT-1];

    // Reference model and per-cycle compare.
    logic [31:0] gold [1024];
    rsp_t        exp_q [$];

    always @(negedge clk) begin : p_model
      logic exp_ready;
      logic exp_valid;
      logic hs;
      rsp_t e;
      if (!arstn) begin
        exp_q.delete();
        checkOutput("reset req_ready", g, 32'(req_ready[g]), 0);
        checkOutput("reset rsp_valid", g, 32'(rsp_valid[g]), 0);
        checkOutput("reset rsp_data", g, rsp_data[g], 0);
        checkOutput("reset ram_en", g, 32'(ram_en[g]), 0);
        checkOutput("reset ram_wr_en", g, 32'(ram_wr_en[g]), 0);
      end else begin
        exp_ready = (exp_q.size() < DEP);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cycle);
        hs        = req_valid[g] && exp_ready;
        checkOutput("req_ready", g, 32'(req_ready[g]), 32'(exp_ready));
        checkOutput("rsp_valid", g, 32'(rsp_valid[g]), 32'(exp_valid));
        if (exp_valid) checkOutput("rsp_data", g, rsp_data[g], exp_q[0].data);
        checkOutput("ram_en", g, 32'(ram_en[g]), 32'(hs));
        checkOutput("ram_rd_en", g, 32'(ram_rd_en[g]), 1);
        checkOutput("ram_wr_en", g, 32'(ram_wr_en[g]), hs ? 32'(req_we) : 0);
        checkOutput("ram_addr", g, 32'(ram_addr[g]), 32'(req_addr));
        checkOutput("ram_data", g, ram_wdata[g], req_data);
        if (exp_valid && rsp_ready) begin
          if (pop_count[g] < 2048) begin
            pop_data[g][pop_count[g]] = rsp_data[g];
            pop_cyc[g][pop_count[g]]  = cycle;
          end
          pop_count[g]++;
          void'(exp_q.pop_front());
        end
        if (hs) begin
          hs_count[g]++;
          hs_cyc[g] = cycle;
          if (req_we == 4'h0) begin
            e.data = gold[req_addr];
            e.due  = cycle + LAT + 1;
            exp_q.push_back(e);
          end else begin
            for (int b = 0; b < 4; b++) begin
              if (req_we[b]) gold[req_addr][8*b +: 8] = req_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pb [NI];
    int hb [NI];
    logic [31:0] exp_word;

    arstn     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NI; i++) begin
      hs_count[i]  = 0;
      hs_cyc[i]    = 0;
      pop_count[i] = 0;
    end
    waitCycles(3);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checkOutput("por req_ready", i, 32'(req_ready[i]), 0);
      checkOutput("por rsp_valid", i, 32'(rsp_valid[i]), 0);
    end
    @(posedge clk);
    #1;
    arstn = 1'b1;

    $display("[TB] preload addresses 0..15");
    for (int k = 0; k < 16; k++) applyStimulus(4'hF, 10'(k), 32'hC0DE0000 + 32'(k));

    $display("[TB] full write then read of 0x005");
    for (int i = 0; i < NI; i++) pb[i] = pop_count[i];
    applyStimulus(4'hF, 10'h005, 32'hDEADBEEF);
    applyStimulus(4'h0, 10'h005, 32'h0);
    waitCycles(10);
    for (int i = 0; i < NI; i++) begin
      checkOutput("wr+rd response count", i, 32'(pop_count[i] - pb[i]), 1);
      checkOutput("wr+rd data", i, pop_data[i][pb[i]], 32'hDEADBEEF);
      checkOutput("read latency", i, 32'(pop_cyc[i][pb[i]] - hs_cyc[i]), (i == 0) ? 2 : 5);
    end

    $display("[TB] byte write merge");
    for (int i = 0; i < NI; i++) pb[i] = pop_count[i];
    applyStimulus(4'hF, 10'h009, 32'h11223344);
    applyStimulus(4'b0010, 10'h009, 32'h0000AB00);
    applyStimulus(4'h0, 10'h009, 32'h0);
    waitCycles(10);
    for (int i = 0; i < NI; i++) begin
      checkOutput("byte write response count", i, 32'(pop_count[i] - pb[i]), 1);
      checkOutput("byte write data", i, pop_data[i][pb[i]], 32'h1122AB44);
    end

    $display("[TB] stall with rsp_ready low");
    rsp_ready = 1'b0;
    for (int i = 0; i < NI; i++) hb[i] = hs_count[i];
    req_valid = '1;
    req_we    = 4'h0;
    for (int k = 0; k < 20; k++) begin
      req_addr = 10'(k % 16);
      waitCycles(1);
    end
    req_we   = 4'hF;
    req_addr = 10'h003;
    req_data = 32'h5555AAAA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) checkOutput("stalled write ready", i, 32'(req_ready[i]), 0);
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    for (int i = 0; i < NI; i++)
      checkOutput("stall handshakes", i, 32'(hs_count[i] - hb[i]), (i == 0) ? 4 : 8);
    rsp_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) checkOutput("ready in pop cycle", i, 32'(req_ready[i]), 0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) checkOutput("ready after pop", i, 32'(req_ready[i]), 1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    waitCycles(20);

    $display("[TB] back-to-back reads 0..7");
    for (int i = 0; i < NI; i++) begin
      pb[i] = pop_count[i];
      hb[i] = hs_count[i];
    end
    req_valid = '1;
    req_we    = 4'h0;
    for (int k = 0; k < 8; k++) begin
      req_addr = 10'(k);
      waitCycles(1);
    end
    req_valid = '0;
    waitCycles(15);
    for (int i = 0; i < NI; i++) begin
      checkOutput("streaming handshakes", i, 32'(hs_count[i] - hb[i]), 8);
      checkOutput("streaming response count", i, 32'(pop_count[i] - pb[i]), 8);
      for (int k = 0; k < 8; k++) begin
        exp_word = (k == 5) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(k);
        checkOutput("streaming data", i, pop_data[i][pb[i] + k], exp_word);
      end
      checkOutput("streaming gapless", i, 32'(pop_cyc[i][pb[i] + 7] - pop_cyc[i][pb[i]]), 7);
    end

    $display("[TB] reset with reads in flight");
    rsp_ready = 1'b0;
    for (int i = 0; i < NI; i++) pb[i] = pop_count[i];
    req_valid = '1;
    req_we    = 4'h0;
    for (int k = 1; k <= 3; k++) begin
      req_addr = 10'(k);
      waitCycles(1);
    end
    req_valid = '0;
    arstn     = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checkOutput("mid reset rsp_valid", i, 32'(rsp_valid[i]), 0);
      checkOutput("mid reset req_ready", i, 32'(req_ready[i]), 0);
    end
    @(posedge clk);
    #1;
    arstn     = 1'b1;
    rsp_ready = 1'b1;
    waitCycles(12);
    for (int i = 0; i < NI; i++)
      checkOutput("no response after reset", i, 32'(pop_count[i] - pb[i]), 0);
    applyStimulus(4'h0, 10'h003, 32'h0);
    waitCycles(10);
    for (int i = 0; i < NI; i++) begin
      checkOutput("post reset response count", i, 32'(pop_count[i] - pb[i]), 1);
      checkOutput("post reset data", i, pop_data[i][pb[i]], 32'hC0DE0003);
    end

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_we    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
      req_addr  = 10'($urandom_range(0, 15));
      req_data  = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      arstn     = (n != 300);
      waitCycles(1);
    end
    arstn     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    waitCycles(30);
    for (int i = 0; i < NI; i++) checkOutput("drained", i, 32'(rsp_valid[i]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
